// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control sequencer.
// Contents:
//   state_t  - sequencer states (also exported on the debug state output)
//   SUB_*    - sub-op codes carried in instr[14:11] when instr[15] = 1
//   ALU_*    - ALU selects the sequencer drives on its own (ADD, SUB)
//   WB_*     - register-file write source encodings
//   is_legal - true for every opcode the sequencer knows how to execute
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMWAIT   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_t;

    localparam logic [3:0] SUB_CMP  = 4'd0;
    localparam logic [3:0] SUB_B    = 4'd1;
    localparam logic [3:0] SUB_BEQ  = 4'd2;
    localparam logic [3:0] SUB_BNE  = 4'd3;
    localparam logic [3:0] SUB_BLT  = 4'd4;
    localparam logic [3:0] SUB_BGT  = 4'd5;
    localparam logic [3:0] SUB_LD   = 4'd6;
    localparam logic [3:0] SUB_ST   = 4'd7;
    localparam logic [3:0] SUB_LDI  = 4'd8;
    localparam logic [3:0] SUB_NOP  = 4'd9;
    localparam logic [3:0] SUB_HALT = 4'd15;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_IMM = 2'd2;

    // Captured opcode is instr[15:11]: {is_sub_op, code}
    localparam logic [4:0] OPC_NOP = {1'b1, SUB_NOP};

    function automatic logic is_legal(input logic [4:0] opc);
        logic ok;
        ok = 1'b0;
        if (!opc[4]) begin
            ok = 1'b1;
        end else begin
            case (opc[3:0])
                SUB_CMP, SUB_B, SUB_BEQ, SUB_BNE, SUB_BLT, SUB_BGT,
                SUB_LD, SUB_ST, SUB_LDI, SUB_NOP, SUB_HALT: ok = 1'b1;
                default:                                      ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control bundle between the sequencer and the datapath / memories.
// master (sequencer): samples instr, flag_z, flag_n, mem_ready; drives the
//   datapath enables (ir_load, pc_inc, pc_load, flags_we, mem_re, mem_we,
//   rf_we), alu_op, wb_sel and the status lines halted, illegal, mem_abort,
//   state.
// slave (datapath side): the mirror image.
interface cpu_sequencer_if;

    logic [15:0] instr;
    logic        flag_z;
    logic        flag_n;
    logic        mem_ready;

    logic        ir_load;
    logic        pc_inc;
    logic        pc_load;
    logic        flags_we;
    logic        mem_re;
    logic        mem_we;
    logic        rf_we;
    logic [3:0]  alu_op;
    logic [1:0]  wb_sel;
    logic        halted;
    logic        illegal;
    logic        mem_abort;
    logic [2:0]  state;

    modport master (
        input  instr, flag_z, flag_n, mem_ready,
        output ir_load, pc_inc, pc_load, flags_we, mem_re, mem_we, rf_we,
               alu_op, wb_sel, halted, illegal, mem_abort, state
    );

    modport slave (
        output instr, flag_z, flag_n, mem_ready,
        input  ir_load, pc_inc, pc_load, flags_we, mem_re, mem_we, rf_we,
               alu_op, wb_sel, halted, illegal, mem_abort, state
    );

endinterface

// File: rtl/cpu_sequencer_branch_cond.sv
// Branch condition evaluation.
// Ports:
//   sub_op - sub-op code of the current instruction
//   z, n   - datapath zero / negative flags
//   taken  - high when sub_op is a branch whose condition holds
module branch_cond
    import cpu_pkg::*;
(
    input  logic [3:0] sub_op,
    input  logic       z,
    input  logic       n,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (sub_op)
            SUB_B:   taken = 1'b1;
            SUB_BEQ: taken = z;
            SUB_BNE: taken = ~z;
            SUB_BLT: taken = n;
            SUB_BGT: taken = ~n & ~z;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer: FETCH -> DECODE -> EXECUTE ->
// [MEMWAIT] -> WRITEBACK, with a terminal HALT state.
// Ports:
//   clock     - system clock, rising edge
//   reset     - asynchronous, active high
//   bus       - cpu_sequencer_if.master: instruction word, flags and
//               mem_ready in; datapath enables, alu_op, wb_sel and
//               status (halted, illegal, mem_abort, state) out
// Parameter:
//   MEM_TIMEOUT - MEMWAIT cycles allowed before the access is aborted
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input logic             clock,
    input logic             reset,
    cpu_sequencer_if.master bus
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [4:0]       op_q;
    logic [CNT_W-1:0] wait_q, wait_d;

    logic [3:0] sub;
    logic       is_alu, is_cmp, is_br, is_ld, is_st, is_ldi, is_halt, legal;
    logic [3:0] alu_sel;
    logic       br_taken;

    logic       ir_load, pc_inc, pc_load, flags_we, mem_re, mem_we, rf_we;
    logic       halted, illegal, mem_abort;
    logic [3:0] alu_op;
    logic [1:0] wb_sel;

    // Only the opcode field of the instruction word is used here.
    logic unused_instr;
    assign unused_instr = ^bus.instr[10:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
            op_q    <= OPC_NOP;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_q == ST_FETCH) begin
                op_q <= bus.instr[15:11];
            end
        end
    end

    assign sub     = op_q[3:0];
    assign is_alu  = ~op_q[4];
    assign is_cmp  = op_q[4] && (sub == SUB_CMP);
    assign is_br   = op_q[4] && (sub >= SUB_B) && (sub <= SUB_BGT);
    assign is_ld   = op_q[4] && (sub == SUB_LD);
    assign is_st   = op_q[4] && (sub == SUB_ST);
    assign is_ldi  = op_q[4] && (sub == SUB_LDI);
    assign is_halt = op_q[4] && (sub == SUB_HALT);
    assign legal   = is_legal(op_q);
    assign alu_sel = is_alu ? sub : (is_cmp ? ALU_SUB : ALU_ADD);

    branch_cond u_branch_cond (
        .sub_op (sub),
        .z      (bus.flag_z),
        .n      (bus.flag_n),
        .taken  (br_taken)
    );

    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        ir_load   = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        flags_we  = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        rf_we     = 1'b0;
        halted    = 1'b0;
        illegal   = 1'b0;
        mem_abort = 1'b0;
        alu_op    = ALU_ADD;
        wb_sel    = WB_ALU;

        case (state_q)
            ST_FETCH: begin
                ir_load = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                pc_inc  = ~is_halt;
                alu_op  = alu_sel;
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                alu_op   = alu_sel;
                pc_load  = is_br & br_taken;
                flags_we = is_cmp;
                illegal  = ~legal;
                mem_re   = is_ld;
                mem_we   = is_st;
                state_d  = (is_ld || is_st) ? ST_MEMWAIT : ST_WRITEBACK;
            end
            ST_MEMWAIT: begin
                // wait_q counts MEMWAIT cycles already spent without
                // mem_ready; the abort cycle is the last one allowed and
                // no longer requests the access.
                if (bus.mem_ready) begin
                    mem_re  = is_ld;
                    mem_we  = is_st;
                    state_d = ST_WRITEBACK;
                end else if (wait_q == WAIT_LAST) begin
                    mem_abort = 1'b1;
                    state_d   = ST_FETCH;
                end else begin
                    mem_re = is_ld;
                    mem_we = is_st;
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_WRITEBACK: begin
                alu_op  = alu_sel;
                rf_we   = is_alu | is_ld | is_ldi;
                wb_sel  = is_ld ? WB_MEM : (is_ldi ? WB_IMM : WB_ALU);
                state_d = is_halt ? ST_HALT : ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Outputs are forced low while reset is held, including the FETCH
    // ir_load that the reset state would otherwise produce.
    assign bus.ir_load   = ir_load   & ~reset;
    assign bus.pc_inc    = pc_inc    & ~reset;
    assign bus.pc_load   = pc_load   & ~reset;
    assign bus.flags_we  = flags_we  & ~reset;
    assign bus.mem_re    = mem_re    & ~reset;
    assign bus.mem_we    = mem_we    & ~reset;
    assign bus.rf_we     = rf_we     & ~reset;
    assign bus.halted    = halted    & ~reset;
    assign bus.illegal   = illegal   & ~reset;
    assign bus.mem_abort = mem_abort & ~reset;
    assign bus.alu_op    = reset ? '0 : alu_op;
    assign bus.wb_sel    = reset ? '0 : wb_sel;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: a per-instruction timeline model
// predicts every output on every cycle; directed scenarios add literal
// checks at known cycle offsets, followed by a randomized instruction mix.
module tb_cpu_sequencer;

    localparam int TMO = 15;

    localparam logic [2:0] S_F = 3'd0;
    localparam logic [2:0] S_D = 3'd1;
    localparam logic [2:0] S_E = 3'd2;
    localparam logic [2:0] S_M = 3'd3;
    localparam logic [2:0] S_W = 3'd4;
    localparam logic [2:0] S_H = 3'd5;

    typedef enum int {K_ALU, K_CMP, K_BR, K_LD, K_ST, K_LDI, K_NOP, K_HALT, K_ILL} kind_t;

    typedef struct packed {
        logic       ir_load;
        logic       pc_inc;
        logic       pc_load;
        logic       flags_we;
        logic       mem_re;
        logic       mem_we;
        logic       rf_we;
        logic [3:0] alu_op;
        logic [1:0] wb_sel;
        logic       halted;
        logic       illegal;
        logic       mem_abort;
        logic [2:0] state;
    } obs_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];
    obs_t trace[$];

    cpu_sequencer_if bus();

    cpu_sequencer #(.MEM_TIMEOUT(TMO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic obs_t observe();
        obs_t o;
        o.ir_load   = bus.ir_load;
        o.pc_inc    = bus.pc_inc;
        o.pc_load   = bus.pc_load;
        o.flags_we  = bus.flags_we;
        o.mem_re    = bus.mem_re;
        o.mem_we    = bus.mem_we;
        o.rf_we     = bus.rf_we;
        o.alu_op    = bus.alu_op;
        o.wb_sel    = bus.wb_sel;
        o.halted    = bus.halted;
        o.illegal   = bus.illegal;
        o.mem_abort = bus.mem_abort;
        o.state     = bus.state;
        return o;
    endfunction

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    // Per-cycle comparison against the model's queued expectations.
    always @(negedge clock) begin
        obs_t e, a;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = observe();
            trace.push_back(a);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle@%0t: got %b, expected %b (ir pci pcl fwe re we rfwe alu wb hlt ill abt st)",
                         $time, a, e);
            end
        end
    end

    function automatic kind_t classify(input logic [15:0] w);
        if (!w[15]) return K_ALU;
        case (w[14:11])
            4'd0:                         return K_CMP;
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5: return K_BR;
            4'd6:                         return K_LD;
            4'd7:                         return K_ST;
            4'd8:                         return K_LDI;
            4'd9:                         return K_NOP;
            4'd15:                        return K_HALT;
            default:                      return K_ILL;
        endcase
    endfunction

    function automatic logic [3:0] aop(input kind_t k, input logic [15:0] w);
        if (k == K_ALU) return w[14:11];
        if (k == K_CMP) return 4'd1;
        return 4'd0;
    endfunction

    function automatic logic cond(input logic [3:0] s, input logic z, input logic n);
        case (s)
            4'd1:    return 1'b1;
            4'd2:    return z;
            4'd3:    return !z;
            4'd4:    return n;
            4'd5:    return !n && !z;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] mk(input logic b, input logic [3:0] code);
        logic [15:0] w;
        w = 16'($urandom);
        w[15] = b;
        w[14:11] = code;
        return w;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic pick(input int f);
        if (f < 0) return rbit();
        return f[0];
    endfunction

    function automatic obs_t blank(input logic [2:0] st);
        obs_t e;
        e = '0;
        e.state = st;
        return e;
    endfunction

    function automatic int count(input string f);
        int c = 0;
        foreach (trace[i]) begin
            case (f)
                "ir_load":   if (trace[i].ir_load)   c++;
                "mem_re":    if (trace[i].mem_re)    c++;
                "mem_we":    if (trace[i].mem_we)    c++;
                "mem_abort": if (trace[i].mem_abort) c++;
                "rf_we":     if (trace[i].rf_we)     c++;
                "illegal":   if (trace[i].illegal)   c++;
                default:     c += 0;
            endcase
        end
        return c;
    endfunction

    // Drive one cycle's inputs just after a rising edge and queue what the
    // outputs must be during that cycle.
    task automatic step(input obs_t e, input logic [15:0] iv, input logic z,
                        input logic n, input logic rdy);
        bus.instr     = iv;
        bus.flag_z    = z;
        bus.flag_n    = n;
        bus.mem_ready = rdy;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    // One instruction: delay = MEMWAIT cycles before mem_ready rises
    // (>= TMO means never); fz/fn force EXECUTE flags (-1 = random);
    // stop > 0 abandons the instruction after that many cycles.
    task automatic run_instr(input logic [15:0] w, input int delay, input int fz,
                             input int fn, input int stop);
        kind_t k;
        obs_t  e;
        logic  z, n;
        int    cnt;
        k = classify(w);
        cnt = 0;

        e = blank(S_F);
        e.ir_load = 1'b1;
        step(e, w, rbit(), rbit(), rbit());
        cnt++;
        if (stop == cnt) return;

        e = blank(S_D);
        e.pc_inc = (k != K_HALT);
        e.alu_op = aop(k, w);
        step(e, 16'($urandom), rbit(), rbit(), rbit());
        cnt++;
        if (stop == cnt) return;

        z = pick(fz);
        n = pick(fn);
        e = blank(S_E);
        e.alu_op   = aop(k, w);
        e.flags_we = (k == K_CMP);
        e.pc_load  = (k == K_BR) && cond(w[14:11], z, n);
        e.illegal  = (k == K_ILL);
        e.mem_re   = (k == K_LD);
        e.mem_we   = (k == K_ST);
        step(e, 16'($urandom), z, n, rbit());
        cnt++;
        if (stop == cnt) return;

        if (k == K_LD || k == K_ST) begin
            for (int i = 0; i < TMO; i++) begin
                e = blank(S_M);
                if (i == delay) begin
                    e.mem_re = (k == K_LD);
                    e.mem_we = (k == K_ST);
                    step(e, 16'($urandom), rbit(), rbit(), 1'b1);
                    break;
                end
                if (i == TMO - 1) begin
                    e.mem_abort = 1'b1;
                    step(e, 16'($urandom), rbit(), rbit(), 1'b0);
                    return;
                end
                e.mem_re = (k == K_LD);
                e.mem_we = (k == K_ST);
                step(e, 16'($urandom), rbit(), rbit(), 1'b0);
                cnt++;
                if (stop == cnt) return;
            end
        end

        e = blank(S_W);
        e.alu_op = aop(k, w);
        e.rf_we  = (k == K_ALU) || (k == K_LD) || (k == K_LDI);
        e.wb_sel = (k == K_LD) ? 2'd1 : ((k == K_LDI) ? 2'd2 : 2'd0);
        step(e, 16'($urandom), rbit(), rbit(), rbit());
    endtask

    task automatic run_halted(input int ncyc);
        obs_t e;
        e = blank(S_H);
        e.halted = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            step(e, 16'($urandom), rbit(), rbit(), rbit());
        end
    endtask

    task automatic do_reset();
        obs_t o;
        reset = 1'b1;
        #2;
        o = observe();
        check("reset_outputs_low", {13'd0, o}, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        trace.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run still active at %0t, expected completion earlier", $time);
        $fatal(1);
    end

    initial begin
        bus.instr     = '0;
        bus.flag_z    = 1'b0;
        bus.flag_n    = 1'b0;
        bus.mem_ready = 1'b0;

        // ADD then NOP: cycle offsets of the 4-cycle ALU sequence
        do_reset();
        run_instr(16'h0000, 0, -1, -1, 0);
        run_instr(mk(1'b1, 4'd9), 0, -1, -1, 0);
        check("add_ir_load_c0", trace[0].ir_load, 1);
        check("add_pc_inc_c1", trace[1].pc_inc, 1);
        check("add_rf_we_c3", trace[3].rf_we, 1);
        check("add_wb_sel_c3", trace[3].wb_sel, 0);
        check("add_alu_op_c3", trace[3].alu_op, 0);
        check("add_ir_load_c4", trace[4].ir_load, 1);

        // CMP then BEQ, taken and not taken
        do_reset();
        run_instr(mk(1'b1, 4'd0), 0, -1, -1, 0);
        run_instr(mk(1'b1, 4'd2), 0, 1, -1, 0);
        check("cmp_flags_we_c2", trace[2].flags_we, 1);
        check("cmp_alu_sub_c2", trace[2].alu_op, 1);
        check("beq_z1_pc_load_c6", trace[6].pc_load, 1);
        do_reset();
        run_instr(mk(1'b1, 4'd0), 0, -1, -1, 0);
        run_instr(mk(1'b1, 4'd2), 0, 0, -1, 0);
        check("beq_z0_pc_load_c6", trace[6].pc_load, 0);

        // BLT n=1, BGT n=0 z=0, BGT z=1
        do_reset();
        run_instr(mk(1'b1, 4'd4), 0, -1, 1, 0);
        run_instr(mk(1'b1, 4'd5), 0, 0, 0, 0);
        run_instr(mk(1'b1, 4'd5), 0, 1, -1, 0);
        check("blt_n1_taken", trace[2].pc_load, 1);
        check("bgt_n0z0_taken", trace[6].pc_load, 1);
        check("bgt_z1_not_taken", trace[10].pc_load, 0);

        // LD with mem_ready after 3 low MEMWAIT cycles
        do_reset();
        run_instr(mk(1'b1, 4'd6), 3, -1, -1, 0);
        check("ld_cycles", trace.size(), 8);
        check("ld_mem_re_cycles", count("mem_re"), 5);
        check("ld_rf_we_c7", trace[7].rf_we, 1);
        check("ld_wb_sel_c7", trace[7].wb_sel, 1);

        // LD ready on the very last permitted MEMWAIT cycle: no abort
        do_reset();
        run_instr(mk(1'b1, 4'd6), TMO - 1, -1, -1, 0);
        check("ld_last_wait_no_abort", count("mem_abort"), 0);
        check("ld_last_wait_rf_we", count("rf_we"), 1);

        // ST with mem_ready never asserted
        do_reset();
        run_instr(mk(1'b1, 4'd7), TMO + 5, -1, -1, 0);
        run_instr(mk(1'b1, 4'd9), 0, -1, -1, 0);
        check("st_abort_cycle", trace[2 + TMO].mem_abort, 1);
        check("st_abort_count", count("mem_abort"), 1);
        check("st_mem_we_cycles", count("mem_we"), TMO);
        check("st_no_rf_we", count("rf_we"), 0);
        check("st_next_is_fetch", trace[3 + TMO].state, 0);

        // HALT is terminal
        do_reset();
        run_instr(mk(1'b1, 4'd15), 0, -1, -1, 0);
        run_halted(6);
        check("halt_no_pc_inc", trace[1].pc_inc, 0);
        check("halt_single_ir_load", count("ir_load"), 1);
        check("halt_halted_high", trace[9].halted, 1);

        // Illegal sub-op 12 behaves as a NOP with one illegal pulse
        do_reset();
        run_instr(mk(1'b1, 4'd12), 0, -1, -1, 0);
        run_instr(mk(1'b1, 4'd9), 0, -1, -1, 0);
        check("illegal_pulse_c2", trace[2].illegal, 1);
        check("illegal_count", count("illegal"), 1);
        check("illegal_refetch_c4", trace[4].ir_load, 1);

        // Reset while in MEMWAIT
        do_reset();
        run_instr(mk(1'b1, 4'd6), TMO + 5, -1, -1, 6);
        check("memwait_before_reset", trace[5].mem_re, 1);
        do_reset();
        run_instr(mk(1'b1, 4'd9), 0, -1, -1, 0);
        check("first_fetch_after_reset", trace[0].ir_load, 1);

        // Randomized instruction mix
        for (int it = 0; it < 400; it++) begin
            logic [15:0] w;
            kind_t       k;
            int          dly;
            trace.delete();
            w = 16'($urandom);
            k = classify(w);
            dly = $urandom_range(0, TMO + 3);
            if ($urandom_range(0, 29) == 0) begin
                run_instr(w, dly, -1, -1, $urandom_range(1, 6));
                do_reset();
            end else begin
                run_instr(w, dly, -1, -1, 0);
                if (k == K_HALT) begin
                    run_halted(3);
                    do_reset();
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, meaning the maximum MEMWAIT cycles before an abort.
REQ-002 SHALL have port clock, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port instr, input, 16, the program-memory word at the current PC.
REQ-005 SHALL have port flag_z / flag_n, input, 1 each, the datapath zero and negative flags from the last CMP.
REQ-006 SHALL have port mem_ready, input, 1, data-memory completion strobe.
REQ-007 SHALL have outputs ir_load, pc_inc, pc_load, flags_we, mem_re, mem_we, rf_we, all 1 bit, the datapath enables.
REQ-008 SHALL have port alu_op, output, 4, the ALU operation select, 0=ADD ... 15=LSR.
REQ-009 SHALL have port wb_sel, output, 2, the register write source: 0=ALU, 1=memory, 2=immediate.
REQ-010 SHALL have outputs halted, illegal, mem_abort, 1 bit each, and state, output, 3, the current state for debug.

Function
REQ-011 SHALL decode the captured opcode as follows: bit 15 = 0 is an ALU op with alu_op = instr[14:11]; bit 15 = 1 selects sub-op instr[14:11]: 0 CMP, 1 B, 2 BEQ, 3 BNE, 4 BLT, 5 BGT, 6 LD, 7 ST, 8 LDI, 9 NOP, 15 HALT; all other codes are illegal.
REQ-012 SHALL implement states FETCH, DECODE, EXECUTE, MEMWAIT, WRITEBACK, HALT.
REQ-013 SHALL move unconditionally FETCH -> DECODE -> EXECUTE.
REQ-014 SHALL move EXECUTE -> MEMWAIT for LD/ST and EXECUTE -> WRITEBACK for all other instructions.
REQ-015 SHALL move MEMWAIT -> WRITEBACK when mem_ready is sampled high.
REQ-016 SHALL move WRITEBACK -> FETCH, or WRITEBACK -> HALT for a HALT instruction; HALT is terminal until reset.
REQ-017 SHALL make every non-memory instruction take exactly 4 cycles, FETCH to WRITEBACK inclusive.
REQ-018 SHALL make LD/ST take 5+N cycles, where N is the number of MEMWAIT cycles with mem_ready low.
REQ-019 SHALL assert ir_load for one cycle in FETCH and capture instr[15:11] internally on that edge; instr is ignored in all other states.
REQ-020 SHALL assert pc_inc in DECODE for every instruction except HALT.
REQ-021 SHALL evaluate branch conditions in EXECUTE using the flags sampled that cycle: BEQ=z, BNE=!z, BLT=n, BGT=!n&!z, B=1.
REQ-022 SHALL assert pc_load for a taken branch in EXECUTE only; a not-taken branch produces no PC action.
REQ-023 SHALL assert flags_we in EXECUTE for CMP only, so that the immediately following branch sees the new flags.
REQ-024 SHALL hold mem_re (LD) or mem_we (ST) high from EXECUTE through the last MEMWAIT cycle and deassert them in WRITEBACK.
REQ-025 SHALL assert rf_we in WRITEBACK only: for ALU ops with wb_sel=0, for LD with wb_sel=1, for LDI with wb_sel=2; wb_sel=0 at all other times.
REQ-026 SHALL drive alu_op from the captured opcode for ALU ops, and 0 otherwise except CMP, which drives SUB (1).
REQ-027 SHALL pulse illegal for one cycle in EXECUTE for an illegal opcode and otherwise execute it as NOP.
REQ-028 SHALL, when MEMWAIT reaches MEM_TIMEOUT cycles without mem_ready, pulse mem_abort, drop mem_re/mem_we, suppress rf_we, and return to FETCH.
REQ-029 SHALL ignore mem_ready outside MEMWAIT; a mem_ready high in the EXECUTE cycle does not shorten the sequence.
REQ-030 SHALL hold halted high in HALT and deassert all enables there.

Reset
REQ-031 SHALL on reset asynchronously enter FETCH, clear the captured opcode to NOP and the timeout counter to 0, and drive all 1-bit outputs, alu_op and wb_sel low.
REQ-032 SHALL abandon any instruction in flight on a reset during MEMWAIT, with mem_re/mem_we low in the same cycle.
REQ-033 SHALL assert ir_load in the first FETCH after reset release.

Structure
REQ-034 SHALL place the state enum, opcode/sub-op constants and wb_sel encodings in the shared package cpu_pkg, reused by cpu_core.
REQ-035 SHALL implement the branch condition evaluation as sub-module branch_cond, a combinational function of sub-op, z and n.

Verification
REQ-036 SHALL verify an ALU op: after reset, instr=ADD -> ir_load at cycle 0, pc_inc at 1, rf_we with wb_sel=0 and alu_op=0 at 3, ir_load again at 4.
REQ-037 SHALL verify CMP followed by BEQ: flags_we at cycle 2, then BEQ with z=1 -> pc_load at cycle 6; the same sequence with z=0 -> no pc_load.
REQ-038 SHALL verify branch conditions: BLT with n=1 -> pc_load; BGT with n=0, z=0 -> pc_load; BGT with z=1 -> no pc_load.
REQ-039 SHALL verify LD with mem_ready delayed 3 cycles: mem_re is high for 5 cycles, then rf_we with wb_sel=1, for 8 cycles total.
REQ-040 SHALL verify ST with mem_ready never asserted: mem_abort pulses after 15 MEMWAIT cycles, no rf_we follows, and the next cycle is FETCH.
REQ-041 SHALL verify HALT, illegal opcode and reset: HALT -> halted high and no further ir_load; an illegal code (sub-op 12) -> one illegal pulse and 4-cycle NOP; reset mid-MEMWAIT -> FETCH with all outputs low.
